// File: rtl/lsu_req_arbiter_pkg.sv
// Shared constants and helpers for the LSU request arbiter and other issue-side arbiters.
package lsu_req_arbiter_pkg;

   // Locations of the ordering flags inside the packed LSU request bundle
   localparam int unsigned REQ_FENCE_BIT = 0;
   localparam int unsigned REQ_AQ_BIT    = 1;
   localparam int unsigned REQ_RL_BIT    = 2;

   // Index width that stays at least one bit for degenerate sizes
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Largest count an outstanding counter of cnt_w bits can hold
   function automatic int unsigned max_outs(input int unsigned cnt_w);
      return (1 << cnt_w) - 1;
   endfunction

endpackage

// File: rtl/lsu_req_arbiter_if.sv
// Issue-side request, LSU FIFO enqueue and completion signals of the LSU request arbiter.
interface lsu_req_arbiter_if #(
   parameter int unsigned NUM_REQ    = 2,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned DEPTH_WARP = 3,
   parameter int unsigned NUM_WARP   = 8
) ();
   import lsu_req_arbiter_pkg::*;

   localparam int unsigned SRC_W = clog2_min1(NUM_REQ);

   logic [NUM_REQ-1:0]            req_valid_i;
   logic [NUM_REQ-1:0]            req_ready_o;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
   logic [NUM_REQ*DEPTH_WARP-1:0] req_wid_i;
   logic [NUM_REQ-1:0]            req_order_i;
   logic                          out_valid_o;
   logic                          out_ready_i;
   logic [DATA_WIDTH-1:0]         out_data_o;
   logic [DEPTH_WARP-1:0]         out_wid_o;
   logic [SRC_W-1:0]              out_src_o;
   logic                          cpl_valid_i;
   logic [DEPTH_WARP-1:0]         cpl_wid_i;
   logic [NUM_WARP-1:0]           warp_idle_o;
   logic                          err_o;

   modport slave (
      input  req_valid_i, req_data_i, req_wid_i, req_order_i, out_ready_i, cpl_valid_i, cpl_wid_i,
      output req_ready_o, out_valid_o, out_data_o, out_wid_o, out_src_o, warp_idle_o, err_o
   );

   modport master (
      output req_valid_i, req_data_i, req_wid_i, req_order_i, out_ready_i, cpl_valid_i, cpl_wid_i,
      input  req_ready_o, out_valid_o, out_data_o, out_wid_o, out_src_o, warp_idle_o, err_o
   );

endinterface

// File: rtl/lsu_req_arbiter_rr_pick.sv
// Round-robin first-one finder: returns the first set bit of i_elig at or after i_ptr, wrapping.
module lsu_req_arbiter_rr_pick
   import lsu_req_arbiter_pkg::*;
#(
   parameter int unsigned N = 2,
   localparam int unsigned IDX_W = clog2_min1(N)
) (
   input  logic [N-1:0]     i_elig,
   input  logic [IDX_W-1:0] i_ptr,
   output logic             o_found_c,
   output logic [IDX_W-1:0] o_idx_c
);

   // Scan from farthest to nearest so the index closest to the pointer is kept last
   always_comb begin : pick
      int unsigned     v_idx;
      logic [IDX_W-1:0] v_sel;
      v_idx     = 0;
      v_sel     = '0;
      o_found_c = 1'b0;
      o_idx_c   = '0;
      for (int k = int'(N) - 1; k >= 0; k--) begin
         v_idx = 32'(i_ptr) + 32'(k);
         if (v_idx >= N) v_idx = v_idx - N;
         v_sel = IDX_W'(v_idx);
         if (i_elig[v_sel]) begin
            o_found_c = 1'b1;
            o_idx_c   = v_sel;
         end
      end
   end

endmodule

// File: rtl/lsu_req_arbiter.sv
// Round-robin arbiter in front of the LSU input FIFO with per-warp outstanding counts
// and fence/aq/rl drain ordering.
module lsu_req_arbiter
   import lsu_req_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 2,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned DEPTH_WARP = 3,
   parameter int unsigned NUM_WARP   = 8,
   parameter int unsigned CNT_W      = 4
) (
   input logic             clk,
   input logic             rst,
   lsu_req_arbiter_if.slave bus
);

   localparam int unsigned      SRC_W    = clog2_min1(NUM_REQ);
   localparam logic [CNT_W-1:0] MAX_OUTS = CNT_W'(max_outs(CNT_W));

   logic [CNT_W-1:0]      r_cnt      [NUM_WARP];
   logic [CNT_W-1:0]      w_cnt_nxt  [NUM_WARP];
   logic [NUM_WARP-1:0]   r_warp_idle;
   logic [NUM_WARP-1:0]   w_idle_nxt;
   logic                  r_err;
   logic                  r_lock;
   logic [SRC_W-1:0]      r_lock_src;
   logic [SRC_W-1:0]      r_ptr;

   logic [DATA_WIDTH-1:0] w_data [NUM_REQ];
   logic [DEPTH_WARP-1:0] w_wid  [NUM_REQ];
   logic [NUM_REQ-1:0]    w_elig;
   logic                  w_rr_found;
   logic [SRC_W-1:0]      w_rr_idx;
   logic [SRC_W-1:0]      w_win;
   logic                  w_valid;
   logic                  w_fire;
   logic [DEPTH_WARP-1:0] w_fire_wid;
   logic                  w_cpl_err;

   // Per-requester unpacking and eligibility against the registered counts only
   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         w_data[i] = bus.req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
         w_wid[i]  = bus.req_wid_i[i*DEPTH_WARP +: DEPTH_WARP];
         w_elig[i] = bus.req_valid_i[i]
                   && (r_cnt[w_wid[i]] != MAX_OUTS)
                   && !(bus.req_order_i[i] && (r_cnt[w_wid[i]] != '0));
      end
   end

   lsu_req_arbiter_rr_pick #(.N(NUM_REQ)) u_rr_pick (
      .i_elig    (w_elig),
      .i_ptr     (r_ptr),
      .o_found_c (w_rr_found),
      .o_idx_c   (w_rr_idx)
   );

   // A stalled grant stays pinned to its source so the FIFO sees a stable request
   always_comb begin
      w_win      = r_lock ? r_lock_src : w_rr_idx;
      w_valid    = !rst && (r_lock ? w_elig[r_lock_src] : w_rr_found);
      w_fire     = w_valid && bus.out_ready_i;
      w_fire_wid = w_wid[w_win];
   end

   assign bus.out_valid_o = w_valid;
   assign bus.out_data_o  = w_valid ? w_data[w_win] : '0;
   assign bus.out_wid_o   = w_valid ? w_fire_wid : '0;
   assign bus.out_src_o   = w_valid ? w_win : '0;
   assign bus.req_ready_o = w_fire ? (NUM_REQ'(1) << w_win) : '0;
   assign bus.warp_idle_o = r_warp_idle;
   assign bus.err_o       = r_err;

   // Same-warp issue and retire cancel; a retire on an empty warp is flagged and ignored
   always_comb begin
      w_cnt_nxt = r_cnt;
      w_cpl_err = bus.cpl_valid_i && (r_cnt[bus.cpl_wid_i] == '0);
      if (!(w_fire && bus.cpl_valid_i && (w_fire_wid == bus.cpl_wid_i))) begin
         if (w_fire)
            w_cnt_nxt[w_fire_wid] = r_cnt[w_fire_wid] + CNT_W'(1);
         if (bus.cpl_valid_i && !w_cpl_err)
            w_cnt_nxt[bus.cpl_wid_i] = r_cnt[bus.cpl_wid_i] - CNT_W'(1);
      end
      for (int unsigned w = 0; w < NUM_WARP; w++)
         w_idle_nxt[w] = (w_cnt_nxt[w] == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr       <= '0;
         r_lock      <= 1'b0;
         r_lock_src  <= '0;
         r_err       <= 1'b0;
         r_warp_idle <= '1;
         for (int unsigned w = 0; w < NUM_WARP; w++)
            r_cnt[w] <= '0;
      end else begin
         r_cnt       <= w_cnt_nxt;
         r_warp_idle <= w_idle_nxt;
         if (w_cpl_err) r_err <= 1'b1;
         if (w_fire) begin
            r_ptr  <= (w_win == SRC_W'(NUM_REQ - 1)) ? '0 : w_win + SRC_W'(1);
            r_lock <= 1'b0;
         end else if (w_valid) begin
            r_lock     <= 1'b1;
            r_lock_src <= w_win;
         end
      end
   end

endmodule

// File: tb/tb_lsu_req_arbiter.sv
// Self-checking bench for lsu_req_arbiter: directed scenarios plus randomized traffic
// against a behavioural model of arbitration, ordering and per-warp counts.
module tb_lsu_req_arbiter;

   localparam int NR   = 2;
   localparam int DW   = 64;
   localparam int WW   = 3;
   localparam int NW   = 8;
   localparam int CW   = 4;
   localparam int MAXO = 15;

   logic clk;
   logic rst;

   lsu_req_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .DEPTH_WARP(WW), .NUM_WARP(NW)) bif ();

   lsu_req_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .DEPTH_WARP(WW), .NUM_WARP(NW), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [NR-1:0] t_valid;
   logic [NR-1:0] t_order;
   logic [DW-1:0] t_data [NR];
   logic [WW-1:0] t_wid  [NR];
   logic          t_ready;
   logic          t_cpl_v;
   logic [WW-1:0] t_cpl_w;

   always_comb begin
      bif.req_valid_i = t_valid;
      bif.req_order_i = t_order;
      for (int i = 0; i < NR; i++) begin
         bif.req_data_i[i*DW +: DW] = t_data[i];
         bif.req_wid_i[i*WW +: WW]  = t_wid[i];
      end
      bif.out_ready_i = t_ready;
      bif.cpl_valid_i = t_cpl_v;
      bif.cpl_wid_i   = t_cpl_w;
   end

   int n_run  = 0;
   int n_fail = 0;

   // Reference model state
   int m_cnt [NW];
   int m_ptr;
   bit m_lock;
   int m_lock_src;
   bit m_err;

   function automatic bit m_elig(input int i);
      int c;
      c = m_cnt[t_wid[i]];
      return t_valid[i] && (c < MAXO) && !(t_order[i] && c > 0);
   endfunction

   function automatic void m_pick(output bit vld, output int win);
      int j;
      vld = 1'b0;
      win = 0;
      if (rst) return;
      if (m_lock) begin
         win = m_lock_src;
         vld = m_elig(win);
      end else begin
         for (int k = 0; k < NR; k++) begin
            j = (m_ptr + k) % NR;
            if (!vld && m_elig(j)) begin
               vld = 1'b1;
               win = j;
            end
         end
      end
   endfunction

   function automatic logic [NW-1:0] m_idle();
      logic [NW-1:0] r;
      r = '0;
      for (int w = 0; w < NW; w++) r[w] = (m_cnt[w] == 0);
      return r;
   endfunction

   // Advance the model by one clock using the inputs currently applied, then clock the DUT
   task automatic tick();
      bit vld, fire;
      int win, fw, cw;
      m_pick(vld, win);
      if (rst) begin
         m_ptr = 0; m_lock = 1'b0; m_lock_src = 0; m_err = 1'b0;
         for (int w = 0; w < NW; w++) m_cnt[w] = 0;
      end else begin
         fire = vld && t_ready;
         fw   = int'(t_wid[win]);
         cw   = int'(t_cpl_w);
         if (t_cpl_v && m_cnt[cw] == 0) m_err = 1'b1;
         if (!(fire && t_cpl_v && fw == cw)) begin
            if (fire) m_cnt[fw]++;
            if (t_cpl_v && m_cnt[cw] > 0) m_cnt[cw]--;
         end
         if (fire) begin
            m_ptr  = (win + 1) % NR;
            m_lock = 1'b0;
         end else if (vld && !t_ready) begin
            m_lock     = 1'b1;
            m_lock_src = win;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_cpl(input int w);
      t_cpl_v = 1'b1;
      t_cpl_w = WW'(w);
      tick();
      t_cpl_v = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; t_valid = 2'b11; t_wid[0] = 0; t_wid[1] = 0; t_ready = 1'b1;
      #2;
      n_run++; if (bif.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bif.out_valid_o); end
      n_run++; if (bif.req_ready_o !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b want 00", bif.req_ready_o); end
      tick();
      rst = 1'b0; t_valid = '0;
      #2;
      n_run++; if (bif.warp_idle_o !== 8'hFF) begin n_fail++; $display("FAIL reset_idle got %h want ff", bif.warp_idle_o); end
      n_run++; if (bif.err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", bif.err_o); end
      tick();
   endtask

   task automatic test_alternate();
      int e;
      t_valid = 2'b11; t_order = '0; t_ready = 1'b1;
      t_wid[0] = 0; t_wid[1] = 7;
      t_data[0] = 64'hA0A0_0000_1111_0000; t_data[1] = 64'hB1B1_0000_2222_0001;
      for (int k = 0; k < 4; k++) begin
         e = k % 2;
         #2;
         n_run++; if (bif.out_src_o !== 1'(e)) begin n_fail++; $display("FAIL alt_src[%0d] got %0d want %0d", k, bif.out_src_o, e); end
         n_run++; if (bif.out_data_o !== t_data[e]) begin n_fail++; $display("FAIL alt_data[%0d] got %h want %h", k, bif.out_data_o, t_data[e]); end
         n_run++; if (bif.req_ready_o !== (2'b01 << e)) begin n_fail++; $display("FAIL alt_ready[%0d] got %b want %b", k, bif.req_ready_o, 2'b01 << e); end
         tick();
      end
      t_valid = '0;
      #2;
      n_run++; if (bif.warp_idle_o !== 8'h7E) begin n_fail++; $display("FAIL alt_idle got %h want 7e", bif.warp_idle_o); end
      do_cpl(0); do_cpl(7); do_cpl(0);
      #2;
      n_run++; if (bif.warp_idle_o !== 8'h7F) begin n_fail++; $display("FAIL alt_idle_one_left got %h want 7f", bif.warp_idle_o); end
      do_cpl(7);
   endtask

   task automatic test_lock();
      t_valid = 2'b01; t_wid[0] = 1; t_data[0] = 64'hD0; t_ready = 1'b1;
      tick();
      t_ready = 1'b0; t_data[0] = 64'hD1D1_D1D1_D1D1_D1D1;
      for (int k = 0; k < 3; k++) begin
         if (k == 1) begin t_valid[1] = 1'b1; t_wid[1] = 2; t_data[1] = 64'hD2; end
         #2;
         n_run++; if (bif.out_src_o !== 1'b0 || bif.out_valid_o !== 1'b1) begin n_fail++; $display("FAIL lock_src[%0d] got v=%b src=%0d want v=1 src=0", k, bif.out_valid_o, bif.out_src_o); end
         n_run++; if (bif.out_data_o !== t_data[0]) begin n_fail++; $display("FAIL lock_data[%0d] got %h want %h", k, bif.out_data_o, t_data[0]); end
         tick();
      end
      t_ready = 1'b1;
      #2;
      n_run++; if (bif.req_ready_o !== 2'b01) begin n_fail++; $display("FAIL lock_release got %b want 01", bif.req_ready_o); end
      tick();
      t_valid[0] = 1'b0;
      #2;
      n_run++; if (bif.req_ready_o !== 2'b10) begin n_fail++; $display("FAIL lock_next got %b want 10", bif.req_ready_o); end
      tick();
      t_valid = '0;
      do_cpl(1); do_cpl(1); do_cpl(2);
   endtask

   task automatic test_order();
      t_valid = 2'b10; t_wid[1] = 2; t_order = '0; t_ready = 1'b1;
      tick(); tick(); tick();
      t_valid = 2'b11; t_wid[0] = 2; t_order[0] = 1'b1; t_data[0] = 64'hD3; t_wid[1] = 5; t_data[1] = 64'hD4;
      for (int k = 0; k < 3; k++) begin
         #2;
         n_run++; if (bif.req_ready_o !== 2'b10 || bif.out_wid_o !== 3'd5) begin n_fail++; $display("FAIL order_hold[%0d] got rdy=%b wid=%0d want rdy=10 wid=5", k, bif.req_ready_o, bif.out_wid_o); end
         tick();
      end
      t_valid[1] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         t_cpl_v = 1'b1; t_cpl_w = 3'd2;
         #2;
         n_run++; if (bif.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL order_drain[%0d] got valid=%b want 0", k, bif.out_valid_o); end
         tick();
      end
      t_cpl_v = 1'b0;
      #2;
      n_run++; if (bif.warp_idle_o[2] !== 1'b1) begin n_fail++; $display("FAIL order_idle2 got %b want 1", bif.warp_idle_o[2]); end
      n_run++; if (bif.req_ready_o !== 2'b01 || bif.out_data_o !== 64'hD3) begin n_fail++; $display("FAIL order_grant got rdy=%b data=%h want 01 d3", bif.req_ready_o, bif.out_data_o); end
      tick();
      t_valid = '0; t_order = '0;
      do_cpl(5); do_cpl(5); do_cpl(5); do_cpl(2);
   endtask

   task automatic test_max();
      t_valid = 2'b01; t_wid[0] = 1; t_order = '0; t_ready = 1'b1;
      for (int k = 0; k < MAXO; k++) begin
         #2;
         n_run++; if (bif.req_ready_o !== 2'b01) begin n_fail++; $display("FAIL max_fill[%0d] got %b want 01", k, bif.req_ready_o); end
         tick();
      end
      for (int k = 0; k < 2; k++) begin
         #2;
         n_run++; if (bif.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL max_stall[%0d] got %b want 0", k, bif.out_valid_o); end
         tick();
      end
      t_cpl_v = 1'b1; t_cpl_w = 3'd1;
      #2;
      n_run++; if (bif.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL max_same_cycle_cpl got %b want 0", bif.out_valid_o); end
      tick();
      t_cpl_v = 1'b0;
      #2;
      n_run++; if (bif.req_ready_o !== 2'b01) begin n_fail++; $display("FAIL max_one_more got %b want 01", bif.req_ready_o); end
      tick();
      #2;
      n_run++; if (bif.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL max_restall got %b want 0", bif.out_valid_o); end
      t_valid = '0;
      for (int k = 0; k < MAXO; k++) do_cpl(1);
      #2;
      n_run++; if (bif.warp_idle_o !== 8'hFF) begin n_fail++; $display("FAIL max_drained got %h want ff", bif.warp_idle_o); end
   endtask

   task automatic test_cnt_err();
      t_valid = 2'b01; t_wid[0] = 4; t_order = '0; t_ready = 1'b1;
      tick();
      t_cpl_v = 1'b1; t_cpl_w = 3'd4;
      #2;
      n_run++; if (bif.req_ready_o !== 2'b01) begin n_fail++; $display("FAIL cnt_fire_cpl got %b want 01", bif.req_ready_o); end
      tick();
      t_valid = '0; t_cpl_v = 1'b0;
      #2;
      n_run++; if (bif.warp_idle_o[4] !== 1'b0) begin n_fail++; $display("FAIL cnt_unchanged got idle4=%b want 0", bif.warp_idle_o[4]); end
      do_cpl(4);
      #2;
      n_run++; if (bif.warp_idle_o[4] !== 1'b1 || bif.err_o !== 1'b0) begin n_fail++; $display("FAIL cnt_drain got idle4=%b err=%b want 1 0", bif.warp_idle_o[4], bif.err_o); end
      do_cpl(6);
      #2;
      n_run++; if (bif.err_o !== 1'b1) begin n_fail++; $display("FAIL err_set got %b want 1", bif.err_o); end
      tick(); tick(); tick();
      n_run++; if (bif.err_o !== 1'b1 || bif.warp_idle_o !== 8'hFF) begin n_fail++; $display("FAIL err_sticky got err=%b idle=%h want 1 ff", bif.err_o, bif.warp_idle_o); end
   endtask

   task automatic test_random(input int ncyc);
      bit vld;
      int win, cw;
      logic [NR-1:0] er;
      for (int c = 0; c < ncyc; c++) begin
         for (int i = 0; i < NR; i++) begin
            if (!t_valid[i] && ($urandom % 3 == 0)) begin
               t_valid[i] = 1'b1;
               t_wid[i]   = WW'($urandom % 4);
               t_order[i] = ($urandom % 8 == 0);
               t_data[i]  = {$urandom, $urandom};
            end
         end
         t_ready = ($urandom % 4 != 0);
         cw      = int'($urandom % 4);
         t_cpl_w = WW'(cw);
         t_cpl_v = ($urandom % 2 == 0) && (m_cnt[cw] > 0);
         #2;
         m_pick(vld, win);
         er = (vld && t_ready) ? (NR'(1) << win) : '0;
         n_run++; if (bif.out_valid_o !== vld) begin n_fail++; $display("FAIL rnd_valid c=%0d got %b want %b", c, bif.out_valid_o, vld); end
         if (vld) begin
            n_run++; if (bif.out_src_o !== 1'(win) || bif.out_data_o !== t_data[win] || bif.out_wid_o !== t_wid[win]) begin
               n_fail++; $display("FAIL rnd_grant c=%0d got src=%0d wid=%0d data=%h want src=%0d wid=%0d data=%h",
                  c, bif.out_src_o, bif.out_wid_o, bif.out_data_o, win, t_wid[win], t_data[win]);
            end
         end
         n_run++; if (bif.req_ready_o !== er) begin n_fail++; $display("FAIL rnd_ready c=%0d got %b want %b", c, bif.req_ready_o, er); end
         n_run++; if (bif.warp_idle_o !== m_idle()) begin n_fail++; $display("FAIL rnd_idle c=%0d got %h want %h", c, bif.warp_idle_o, m_idle()); end
         n_run++; if (bif.err_o !== m_err) begin n_fail++; $display("FAIL rnd_err c=%0d got %b want %b", c, bif.err_o, m_err); end
         tick();
         if (vld && er != '0) t_valid[win] = 1'b0;
      end
      t_valid = '0; t_order = '0; t_cpl_v = 1'b0; t_ready = 1'b1;
   endtask

   task automatic test_reset_mid();
      rst = 1'b1; t_valid = '0;
      tick();
      rst = 1'b0;
      do_cpl(6);
      t_valid = 2'b01; t_wid[0] = 6; t_order = '0; t_ready = 1'b1;
      tick();
      t_valid = 2'b10; t_wid[1] = 3; t_ready = 1'b0;
      #2;
      n_run++; if (bif.out_src_o !== 1'b1 || bif.err_o !== 1'b1) begin n_fail++; $display("FAIL rmid_pre got src=%0d err=%b want 1 1", bif.out_src_o, bif.err_o); end
      tick();
      rst = 1'b1; t_valid = 2'b11; t_wid[0] = 0;
      #2;
      n_run++; if (bif.out_valid_o !== 1'b0 || bif.req_ready_o !== 2'b00) begin n_fail++; $display("FAIL rmid_during got v=%b rdy=%b want 0 00", bif.out_valid_o, bif.req_ready_o); end
      tick();
      rst = 1'b0; t_valid = '0;
      #2;
      n_run++; if (bif.out_valid_o !== 1'b0 || bif.warp_idle_o !== 8'hFF || bif.err_o !== 1'b0) begin
         n_fail++; $display("FAIL rmid_after got v=%b idle=%h err=%b want 0 ff 0", bif.out_valid_o, bif.warp_idle_o, bif.err_o);
      end
      tick();
      t_valid = 2'b11; t_ready = 1'b1;
      #2;
      n_run++; if (bif.req_ready_o !== 2'b01) begin n_fail++; $display("FAIL rmid_ptr got %b want 01", bif.req_ready_o); end
      tick();
      t_valid = '0;
   endtask

   initial begin
      rst = 1'b1; t_valid = '0; t_order = '0; t_ready = 1'b0; t_cpl_v = 1'b0; t_cpl_w = '0;
      for (int i = 0; i < NR; i++) begin t_data[i] = '0; t_wid[i] = '0; end
      m_ptr = 0; m_lock = 1'b0; m_lock_src = 0; m_err = 1'b0;
      for (int w = 0; w < NW; w++) m_cnt[w] = 0;
      #1;
      test_reset();
      test_alternate();
      test_lock();
      test_order();
      test_max();
      test_cnt_err();
      test_random(600);
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
